// File: rtl/div_ctrl_pkg.sv
// Shared types for the divide sequencing controller and its unsigned core.
//   u64/i64/u128 : datapath typedefs used across the mult/div unit
//   div_op_t     : request opcode (DIV, DIVU, REM, REMU)
//   div_state_t  : controller state encoding
package div_ctrl_pkg;

  typedef logic [63:0]        u64;
  typedef logic signed [63:0] i64;
  typedef logic [127:0]       u128;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef logic [2:0] div_state_t;

  localparam div_state_t ST_IDLE  = 3'd0;
  localparam div_state_t ST_SHORT = 3'd1;
  localparam div_state_t ST_RUN   = 3'd2;
  localparam div_state_t ST_FIX   = 3'd3;
  localparam div_state_t ST_DONE  = 3'd4;

  // Most-negative values after conditioning (W form is already sign-extended).
  localparam u64 MIN_X64 = 64'h8000_0000_0000_0000;
  localparam u64 MIN_W64 = 64'hFFFF_FFFF_8000_0000;

endpackage

// File: rtl/div_ctrl_divider.sv
// Iterative 64-bit unsigned restoring divider, one quotient bit per cycle.
//   clk      : clock
//   reset    : synchronous, active-high; returns the core to idle
//   i_valid  : single-cycle start pulse, sampled only while idle
//   i_a/i_b  : dividend / divisor (divisor is never zero here)
//   o_done   : high for one cycle in the working state once all bits are done
//   o_result : {remainder, quotient}, valid while o_done is high
module divider
  import div_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [63:0]   i_a,
  input  logic [63:0]   i_b,
  output logic          o_done,
  output logic [127:0]  o_result
);

  logic        r_busy;
  logic [6:0]  r_cnt;
  u64          r_rem;
  u64          r_quo;
  u64          r_dvs;
  logic [64:0] w_shift;
  logic [64:0] w_diff;

  // Partial remainder is always below the divisor, so the shifted value fits
  // in 65 bits and bit 64 of the difference is a clean borrow flag.
  assign w_shift  = {r_rem, r_quo[63]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign o_done   = r_busy && (r_cnt == 7'd0);
  assign o_result = {r_rem, r_quo};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= 7'd0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
    end else if (!r_busy) begin
      if (i_valid) begin
        r_busy <= 1'b1;
        r_cnt  <= 7'd64;
        r_rem  <= '0;
        r_quo  <= i_a;
        r_dvs  <= i_b;
      end
    end else if (r_cnt == 7'd0) begin
      r_busy <= 1'b0;
    end else begin
      r_cnt <= r_cnt - 7'd1;
      if (!w_diff[64]) begin
        r_rem <= w_diff[63:0];
        r_quo <= {r_quo[62:0], 1'b1};
      end else begin
        r_rem <= w_shift[63:0];
        r_quo <= {r_quo[62:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// RV64M divide sequencer on top of the unsigned iterative core.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_op, req_word      : 0=DIV 1=DIVU 2=REM 3=REMU; word = W form
//   req_a, req_b          : dividend, divisor
//   flush                 : abort in-flight work, drop pending response
//   resp_valid/resp_ready : response handshake, resp_data held until taken
//   busy                  : controller not in IDLE
//
// state | meaning
// IDLE  | waiting for a request
// SHORT | divide-by-zero or signed overflow, core bypassed
// RUN   | waiting for the core to finish
// FIX   | sign fixup, op select, W-form extension
// DONE  | response presented until accepted
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN = 64  // the core is fixed at 64 bits
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  function automatic u64 condition(u64 x, logic word, logic is_signed);
    if (!word)          return x;
    else if (is_signed) return {{32{x[31]}}, x[31:0]};
    else                return {32'h0, x[31:0]};
  endfunction

  // Most-negative maps to itself, which is its correct unsigned magnitude.
  function automatic u64 magnitude(u64 x, logic is_signed);
    return (is_signed && x[63]) ? (~x + 64'd1) : x;
  endfunction

  function automatic u64 finish(u64 q, u64 r, logic is_rem, logic word);
    u64 v;
    v = is_rem ? r : q;
    return word ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  div_state_t r_state;
  div_op_t    r_op;
  logic       r_word;
  logic       r_sign_a;
  logic       r_sign_b;
  logic       r_div_zero;
  u64         r_a_cond;
  u64         r_q;
  u64         r_r;
  u64         r_resp_data;

  div_op_t    w_op;
  logic       w_signed;
  logic       w_accept;
  u64         w_a_cond;
  u64         w_b_cond;
  u64         w_a_mag;
  u64         w_b_mag;
  logic       w_div_zero;
  logic       w_ovf;
  logic       w_core_valid;
  logic       w_core_rst;
  logic       w_core_done;
  u128        w_core_res;
  logic       w_r_signed;
  logic       w_r_is_rem;
  u64         w_q_fix;
  u64         w_r_fix;
  u64         w_short_q;
  u64         w_short_r;

  assign w_op       = div_op_t'(req_op);
  assign w_signed   = (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_accept   = req_valid && req_ready && !flush;
  assign w_a_cond   = condition(req_a, req_word, w_signed);
  assign w_b_cond   = condition(req_b, req_word, w_signed);
  assign w_a_mag    = magnitude(w_a_cond, w_signed);
  assign w_b_mag    = magnitude(w_b_cond, w_signed);
  assign w_div_zero = (w_b_cond == '0);
  assign w_ovf      = w_signed && (w_b_cond == '1) &&
                      (w_a_cond == (req_word ? MIN_W64 : MIN_X64));

  assign w_core_valid = w_accept && !w_div_zero && !w_ovf;
  assign w_core_rst   = reset || flush;

  divider u_divider (
    .clk      (clk),
    .reset    (w_core_rst),
    .i_valid  (w_core_valid),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_done   (w_core_done),
    .o_result (w_core_res)
  );

  assign w_r_signed = (r_op == OP_DIV) || (r_op == OP_REM);
  assign w_r_is_rem = (r_op == OP_REM) || (r_op == OP_REMU);
  assign w_q_fix    = (w_r_signed && (r_sign_a != r_sign_b)) ? (~r_q + 64'd1) : r_q;
  assign w_r_fix    = (w_r_signed && r_sign_a) ? (~r_r + 64'd1) : r_r;
  // Overflow: quotient is the dividend itself and remainder is zero.
  assign w_short_q  = r_div_zero ? '1 : r_a_cond;
  assign w_short_r  = r_div_zero ? r_a_cond : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_DIV;
      r_word      <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_div_zero  <= 1'b0;
      r_a_cond    <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_resp_data <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op       <= w_op;
            r_word     <= req_word;
            r_sign_a   <= w_signed && w_a_cond[63];
            r_sign_b   <= w_signed && w_b_cond[63];
            r_div_zero <= w_div_zero;
            r_a_cond   <= w_a_cond;
            r_state    <= (w_div_zero || w_ovf) ? ST_SHORT : ST_RUN;
          end
        end
        ST_SHORT: begin
          r_resp_data <= finish(w_short_q, w_short_r, w_r_is_rem, r_word);
          r_state     <= ST_DONE;
        end
        ST_RUN: begin
          if (w_core_done) begin
            r_q     <= w_core_res[63:0];
            r_r     <= w_core_res[127:64];
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_resp_data <= finish(w_q_fix, w_r_fix, w_r_is_rem, r_word);
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign resp_valid = (r_state == ST_DONE);
  assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_word;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_ctrl #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_word(req_word), .req_a(req_a), .req_b(req_b),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .busy(busy)
  );

  // Reference: RV64M divide rules expressed with plain integer arithmetic.
  function automatic logic [63:0] ref_div(logic [1:0] op, bit word, logic [63:0] a, logic [63:0] b);
    bit sgn;
    i64 sa, sb, min_v;
    logic [63:0] ua, ub, q, r, res;
    sgn = (op == 2'd0) || (op == 2'd2);
    if (word) begin
      sa = {{32{a[31]}}, a[31:0]};
      sb = {{32{b[31]}}, b[31:0]};
      ua = {32'h0, a[31:0]};
      ub = {32'h0, b[31:0]};
      min_v = 64'shFFFF_FFFF_8000_0000;
    end else begin
      sa = a; sb = b; ua = a; ub = b;
      min_v = 64'sh8000_0000_0000_0000;
    end
    if (sgn) begin
      if (sb == 0)                       begin q = '1; r = sa; end
      else if (sb == -1 && sa == min_v)  begin q = sa; r = '0; end
      else                               begin q = sa / sb; r = sa % sb; end
    end else begin
      if (ub == 0) begin q = '1; r = ua; end
      else         begin q = ua / ub; r = ua % ub; end
    end
    res = op[1] ? r : q;
    if (word) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  function automatic bit ref_short(logic [1:0] op, bit word, logic [63:0] a, logic [63:0] b);
    bit sgn;
    sgn = (op == 2'd0) || (op == 2'd2);
    if (word)
      return (b[31:0] == 32'h0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else
      return (b == 64'h0) || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic logic [63:0] gen_operand(bit word);
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = {$urandom, $urandom};
      1: v = 64'($urandom_range(0, 20));
      2: v = -64'($urandom_range(1, 20));
      3: v = 64'h0;
      4: v = word ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
      5: v = '1;
      default: v = 64'($urandom) >> $urandom_range(0, 31);
    endcase
    if (word) v[63:32] = $urandom;
    return v;
  endfunction

  task automatic issue(input logic [1:0] op, input bit word, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_op = op; req_word = word; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called one negedge after the accept edge; lat counts cycles since accept.
  task automatic wait_resp(output int lat, output bit to);
    lat = 1;
    while (!resp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    to = !resp_valid;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input bit word, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] data, output int lat, output bit to);
    issue(op, word, a, b);
    wait_resp(lat, to);
    data = resp_data;
    if (to) pulse_flush();
    else    ack();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_tests++; if (resp_data !== 64'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
  endtask

  typedef struct {
    logic [1:0]  op;
    bit          word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    logic [63:0] data;
    int lat;
    bit to;
    v.push_back('{op:2'd0, word:1'b0, a:-64'd7, b:64'd2, exp:64'hFFFF_FFFF_FFFF_FFFD, lat:0});
    v.push_back('{op:2'd2, word:1'b0, a:-64'd7, b:64'd2, exp:64'hFFFF_FFFF_FFFF_FFFF, lat:0});
    v.push_back('{op:2'd1, word:1'b0, a:64'hFFFF_FFFF_FFFF_FFFF, b:64'h10, exp:64'h0FFF_FFFF_FFFF_FFFF, lat:0});
    v.push_back('{op:2'd3, word:1'b0, a:64'hFFFF_FFFF_FFFF_FFFF, b:64'h10, exp:64'hF, lat:0});
    v.push_back('{op:2'd0, word:1'b0, a:64'd123, b:64'd0, exp:64'hFFFF_FFFF_FFFF_FFFF, lat:2});
    v.push_back('{op:2'd2, word:1'b0, a:64'd123, b:64'd0, exp:64'd123, lat:2});
    v.push_back('{op:2'd0, word:1'b0, a:64'h8000_0000_0000_0000, b:'1, exp:64'h8000_0000_0000_0000, lat:2});
    v.push_back('{op:2'd2, word:1'b0, a:64'h8000_0000_0000_0000, b:'1, exp:64'h0, lat:2});
    v.push_back('{op:2'd0, word:1'b1, a:64'h0000_0000_8000_0000, b:64'hFFFF_FFFF, exp:64'hFFFF_FFFF_8000_0000, lat:2});
    v.push_back('{op:2'd1, word:1'b1, a:64'h1_FFFF_FFFE, b:64'd1, exp:64'hFFFF_FFFF_FFFF_FFFE, lat:0});
    v.push_back('{op:2'd2, word:1'b1, a:-64'd5, b:64'd3, exp:64'hFFFF_FFFF_FFFF_FFFE, lat:0});
    for (int i = 0; i < v.size(); i++) begin
      run_op(v[i].op, v[i].word, v[i].a, v[i].b, data, lat, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL directed_%0d_timeout: no resp_valid within %0d cycles", i, lat); end
      n_tests++;
      if (data !== v[i].exp) begin n_fail++; $display("FAIL directed_%0d_data: got %h expected %h", i, data, v[i].exp); end
      if (v[i].lat != 0) begin
        n_tests++;
        if (lat != v[i].lat) begin n_fail++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, v[i].lat); end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    bit          word;
    logic [63:0] a, b, exp, data;
    int lat;
    bit to, sc;
    for (int i = 0; i < 60; i++) begin
      op   = 2'($urandom_range(0, 3));
      word = 1'($urandom_range(0, 1));
      a    = gen_operand(word);
      b    = gen_operand(word);
      exp  = ref_div(op, word, a, b);
      sc   = ref_short(op, word, a, b);
      run_op(op, word, a, b, data, lat, to);
      n_tests++;
      if (data !== exp || to) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d w=%0d a=%h b=%h: got %h expected %h timeout=%0d", i, op, word, a, b, data, exp, to);
      end
      n_tests++;
      if ((lat == 2) != sc) begin n_fail++; $display("FAIL random_%0d_path: latency %0d, short-cut expected %0d", i, lat, sc); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp, first;
    int lat;
    bit to, bad_data, bad_rdy, bad_vld;
    exp = ref_div(2'd0, 1'b0, 64'd1000, -64'd7);
    issue(2'd0, 1'b0, 64'd1000, -64'd7);
    wait_resp(lat, to);
    n_tests++;
    if (to || resp_data !== exp) begin n_fail++; $display("FAIL hold_first: got %h expected %h timeout=%0d", resp_data, exp, to); end
    first = resp_data;
    // Offer a new request while the response is held; it must wait.
    req_op = 2'd1; req_word = 1'b0; req_a = 64'd100; req_b = 64'd7; req_valid = 1'b1;
    bad_data = 0; bad_rdy = 0; bad_vld = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_data !== first) bad_data = 1;
      if (req_ready !== 1'b0)  bad_rdy = 1;
      if (resp_valid !== 1'b1) bad_vld = 1;
    end
    n_tests++; if (bad_data) begin n_fail++; $display("FAIL hold_data_stable: got %h expected %h", resp_data, first); end
    n_tests++; if (bad_rdy)  begin n_fail++; $display("FAIL hold_req_ready: got 1 at least once, expected 0"); end
    n_tests++; if (bad_vld)  begin n_fail++; $display("FAIL hold_resp_valid: got 0 at least once, expected 1"); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL handshake_no_accept: busy got %b expected 0", busy); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(lat, to);
    n_tests++;
    if (to || resp_data !== 64'd14) begin n_fail++; $display("FAIL back_to_back_divu: got %h expected %h timeout=%0d", resp_data, 64'd14, to); end
    if (to) pulse_flush(); else ack();
  endtask

  task automatic test_flush();
    logic [63:0] data;
    int lat, seen;
    bit to;
    issue(2'd0, 1'b0, 64'h7654_3210_FEDC_BA98, 64'd13);
    repeat (20) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b expected 1", busy); end
    pulse_flush();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_run_busy: got %b expected 0", busy); end
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL flush_run_no_resp: resp_valid seen %0d cycles, expected 0", seen); end
    run_op(2'd1, 1'b0, 64'd100, 64'd7, data, lat, to);
    n_tests++; if (to || data !== 64'd14) begin n_fail++; $display("FAIL flush_then_divu: got %h expected %h timeout=%0d", data, 64'd14, to); end

    // flush in the same cycle as a request: nothing is accepted
    @(negedge clk);
    req_op = 2'd1; req_word = 1'b0; req_a = 64'd100; req_b = 64'd7; req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_vs_req: busy got %b expected 0", busy); end

    // flush during the short-cut cycle
    issue(2'd0, 1'b0, 64'd5, 64'd0);
    pulse_flush();
    @(negedge clk);
    n_tests++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_short: resp_valid=%b busy=%b expected 0 0", resp_valid, busy); end

    // flush while a response is pending
    issue(2'd3, 1'b0, 64'd100, 64'd7);
    wait_resp(lat, to);
    pulse_flush();
    n_tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_done: resp_valid=%b req_ready=%b expected 0 1", resp_valid, req_ready); end

    // reset mid-operation
    issue(2'd2, 1'b1, 64'd99, 64'd4);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_mid_run: busy=%b resp_valid=%b resp_data=%h expected 0 0 0", busy, resp_valid, resp_data);
    end
    run_op(2'd3, 1'b0, 64'd100, 64'd7, data, lat, to);
    n_tests++; if (to || data !== 64'd2) begin n_fail++; $display("FAIL reset_then_remu: got %h expected %h timeout=%0d", data, 64'd2, to); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_word = 1'b0;
    req_a = '0; req_b = '0; flush = 1'b0; resp_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller for the 64-bit iterative unsigned divider core in the execute stage's mult/div unit.
- Implements full RV64M divide semantics on top of the unsigned core:
  - DIV/DIVU/REM/REMU and the W forms DIVW/DIVUW/REMW/REMUW.
  - Operand sign conditioning and result sign fixup.
  - Divide-by-zero and signed-overflow short-cuts that bypass the core.
  - Valid/ready request and response handshakes, plus pipeline flush.

Parameters:
- XLEN, 64, datapath width; the core is fixed at 64, and only 64 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- req_word  in  1  1 = W form (low 32 bits of each operand; result sign-extended)
- req_a  in  64  dividend
- req_b  in  64  divisor
- flush  in  1  abort the in-flight operation and drop any pending response
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts the result
- resp_data  out  64  result
- busy  out  1  state != IDLE

Behaviour:
- States are IDLE, SHORT, RUN, FIX, DONE. On reset: state=IDLE, resp_valid=0, resp_data=0, busy=0, req_ready=1.
- req_ready=1 only in IDLE. A request is accepted on req_valid && req_ready. On accept, latch op, word, sign_a, sign_b, and the conditioned operands.
- Conditioning:
  - W forms take bits [31:0]. Signed ops sign-extend them; unsigned ops zero-extend them.
  - Signed ops then take the magnitude: |x| via two's complement, with the most-negative value mapping to itself as unsigned.
- Special cases are detected at accept, from the conditioned operands, and go to state SHORT:
  - b==0: quotient = all ones, remainder = a (conditioned, pre-magnitude).
  - Signed op with a=most-negative (2^63, or 2^31 for W) and b=-1: quotient = a, remainder = 0.
- SHORT lasts 1 cycle: it computes the result, then goes to DONE. resp_valid rises 2 cycles after accept.
- Normal path:
  - IDLE→RUN. On the accept cycle, pulse the core valid for exactly 1 cycle with the magnitudes.
  - Stay in RUN until the core reports done while in its working state.
  - Capture quotient C[63:0] and remainder C[127:64], then go to FIX.
- FIX lasts 1 cycle:
  - Quotient is negated when signed and sign_a != sign_b. Remainder is negated when signed and sign_a=1.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
  - W forms sign-extend bit 31 to 64 bits, including DIVUW/REMUW.
  - Then go to DONE.
- DONE: resp_valid=1 and resp_data is held stable until resp_ready. On resp_valid && resp_ready, return to IDLE. No new request is accepted in the same cycle as the response handshake.
- Flush:
  - Takes effect in any state: next state=IDLE and resp_valid=0 next cycle.
  - The core's reset is driven by reset || flush, so the core returns to its initial state.
  - If flush and req_valid are asserted in the same cycle, flush wins: nothing is accepted.
- Reset mid-operation: identical to flush, and the registers return to their reset values.
- The controller must not depend on the exact core latency; it waits only on the core's done. The current core gives a data result 65 cycles after the valid pulse.

Decomposition:
- pipes package:
  - div_op_t enum (DIV, DIVU, REM, REMU).
  - div_state_t enum (IDLE, SHORT, RUN, FIX, DONE).
- common package: the i64/u64/u128 typedefs already in use.
- One sub-module: the existing iterative unsigned divider core `divider`, instantiated once.
- Sign conditioning and fixup are local functions, not separate modules.

Test Plan:
- DIV a=-7, b=2 → resp_data=-3 (0xFFFF_FFFF_FFFF_FFFD). REM with the same operands → -1.
- DIVU a=0xFFFF_FFFF_FFFF_FFFF, b=0x10 → 0x0FFF_FFFF_FFFF_FFFF. REMU → 0xF.
- Divide by zero:
  - DIV a=123, b=0 → 0xFFFF_FFFF_FFFF_FFFF, with resp_valid exactly 2 cycles after accept.
  - REM a=123, b=0 → 123.
- Overflow:
  - DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000. REM → 0.
  - DIVW a=0x0000_0000_8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- DIVUW a=0x1_FFFF_FFFE, b=1 → 0xFFFF_FFFF_FFFF_FFFE (bit-31 sign-extension). REMW a=-5, b=3 → -2.
- Handshake and flush:
  - Hold resp_ready=0 for 10 cycles in DONE → resp_data stable and req_ready=0.
  - Assert flush in mid-RUN → no resp_valid. An immediately following DIVU 100/7 returns 14 correctly.
